// File: rtl/button_edit_controller.sv
// ============================================================================
// Module      : button_edit_controller
// Description : Date/time field-edit controller. Mode button cycles the selected
//               field; up/down buttons emit inc/dec pulses, plus inactivity
//               timeout and blink. Auto-repeat built only with BUTTON_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_edit_controller #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned TIMEOUT      = 1_000_000_000,
  parameter int unsigned BLINK_HALF   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       edit_active,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DAY   = 3'd1,
    S_MONTH = 3'd2,
    S_YEAR  = 3'd3,
    S_HOUR  = 3'd4,
    S_MIN   = 3'd5
  } state_t;

  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0 || TIMEOUT == 0 || BLINK_HALF == 0) begin : g_param_check
    $error("button_edit_controller: timing parameters must be non-zero");
  end

  state_t      state_q, state_d;
  logic        mode_q, up_q, down_q;
  logic        edit_active_q, edit_active_d;
  logic        inc_pulse_q, inc_pulse_d;
  logic        dec_pulse_q, dec_pulse_d;
  logic        blink_q, blink_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;

  logic mode_rise, up_rise, down_rise, any_rise, both_held;
  logic rpt_fire_up, rpt_fire_down, activity;

  assign mode_rise = btn_mode & ~mode_q;
  assign up_rise   = btn_up & ~up_q;
  assign down_rise = btn_down & ~down_q;
  assign any_rise  = mode_rise | up_rise | down_rise;
  assign both_held = btn_up & btn_down;

`ifdef BUTTON_AUTO_REPEAT_EN
  // Repeat only runs for a button whose own press was accepted outside IDLE,
  // so a button held through reset stays silent until re-pressed.
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_phase_q, rpt_phase_d;
  logic        armed_q, armed_d;
  logic        hold_up_cont, hold_down_cont, rpt_hit;

  always_comb begin
    hold_up_cont   = btn_up & ~btn_down & up_q & ~down_q;
    hold_down_cont = btn_down & ~btn_up & down_q & ~up_q;
    rpt_hit        = rpt_phase_q ? (rpt_cnt_q == REPEAT_RATE - 1)
                                 : (rpt_cnt_q == REPEAT_DELAY - 1);
    rpt_fire_up    = 1'b0;
    rpt_fire_down  = 1'b0;
    rpt_cnt_d      = '0;
    rpt_phase_d    = 1'b0;
    armed_d        = armed_q;

    if (state_q == S_IDLE || !(btn_up | btn_down)) begin
      armed_d = 1'b0;
    end else if (up_rise | down_rise) begin
      armed_d = 1'b1;
    end

    if (armed_q && state_q != S_IDLE && (hold_up_cont | hold_down_cont)) begin
      if (rpt_hit) begin
        rpt_fire_up   = hold_up_cont;
        rpt_fire_down = hold_down_cont;
        rpt_phase_d   = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + 32'd1;
        rpt_phase_d = rpt_phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      armed_q     <= armed_d;
    end
  end
`else
  assign rpt_fire_up   = 1'b0;
  assign rpt_fire_down = 1'b0;
`endif

  assign activity = any_rise | rpt_fire_up | rpt_fire_down;

  always_comb begin
    state_d       = state_q;
    inc_pulse_d   = 1'b0;
    dec_pulse_d   = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    blink_d       = blink_q;
    blink_cnt_d   = blink_cnt_q;

    if (activity) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q < TIMEOUT) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    if (mode_rise) begin
      case (state_q)
        S_IDLE:  state_d = S_DAY;
        S_DAY:   state_d = S_MONTH;
        S_MONTH: state_d = S_YEAR;
        S_YEAR:  state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && !activity && tmo_cnt_q == TIMEOUT) begin
      state_d = S_IDLE;
    end

    // Mode edges and two-button chords swallow any up/down request.
    if (state_q != S_IDLE && !mode_rise && !both_held) begin
      inc_pulse_d = up_rise | rpt_fire_up;
      dec_pulse_d = down_rise | rpt_fire_down;
    end

    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_d     = (state_d != S_IDLE);
    end else if (state_q == S_IDLE) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_HALF - 1) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 32'd1;
    end

    edit_active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      edit_active_q <= 1'b0;
      inc_pulse_q   <= 1'b0;
      dec_pulse_q   <= 1'b0;
      blink_q       <= 1'b0;
      tmo_cnt_q     <= '0;
      blink_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= btn_mode;
      up_q          <= btn_up;
      down_q        <= btn_down;
      edit_active_q <= edit_active_d;
      inc_pulse_q   <= inc_pulse_d;
      dec_pulse_q   <= dec_pulse_d;
      blink_q       <= blink_d;
      tmo_cnt_q     <= tmo_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign field_sel   = state_q;
  assign edit_active = edit_active_q;
  assign inc_pulse   = inc_pulse_q;
  assign dec_pulse   = dec_pulse_q;
  assign blink       = blink_q;

endmodule

`default_nettype wire

// File: doc/button_edit_controller.md
BUTTON_EDIT_CONTROLLER -- requirements
Module: button_edit_controller

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, 50_000_000: cycles an up/down button is held after its press pulse before the first auto-repeat pulse.
REQ-002 SHALL have parameter REPEAT_RATE, 10_000_000: cycles between successive auto-repeat pulses.
REQ-003 SHALL have parameter TIMEOUT, 1_000_000_000: cycles without any button rising edge before edit mode exits.
REQ-004 SHALL have parameter BLINK_HALF, 25_000_000: half-period of blink, in cycles.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port btn_mode  input  1  debounced mode button level, synchronous to clk.
REQ-008 SHALL have port btn_up  input  1  debounced increment button level.
REQ-009 SHALL have port btn_down  input  1  debounced decrement button level.
REQ-010 SHALL have port edit_active  output  1  high while any field is selected.
REQ-011 SHALL have port field_sel  output  3  0=none, 1=day, 2=month, 3=year, 4=hour, 5=minute.
REQ-012 SHALL have port inc_pulse  output  1  one-cycle increment request for field_sel.
REQ-013 SHALL have port dec_pulse  output  1  one-cycle decrement request for field_sel.
REQ-014 SHALL have port blink  output  1  display-blink enable for the selected field.

Function
REQ-015 SHALL register each button once per cycle; a rising edge is current level high and registered level low.
REQ-016 SHALL implement FSM IDLE, DAY, MONTH, YEAR, HOUR, MIN; a btn_mode edge advances IDLE->DAY->MONTH->YEAR->HOUR->MIN->IDLE.
REQ-017 SHALL drive field_sel from the state (IDLE=0 ... MIN=5) and edit_active = (field_sel != 0), both registered.
REQ-018 SHALL assert inc_pulse (dec_pulse) for exactly one cycle, in the cycle after a btn_up (btn_down) rising edge is sampled, only when not IDLE.
REQ-019 SHALL ignore up/down edges in IDLE: no pulse, no state change.
REQ-020 SHALL give btn_mode priority: a mode edge coinciding with an up/down edge or repeat event suppresses that pulse.
REQ-021 SHALL suppress both pulses when btn_up and btn_down are both high (simultaneous edges or one held while the other pressed); repeat timing restarts when exactly one remains high.
REQ-022 SHALL never assert inc_pulse and dec_pulse in the same cycle.
REQ-023 SHALL reload a 32-bit timeout counter on every rising edge of any button and on every auto-repeat pulse; on reaching TIMEOUT in a non-IDLE state, SHALL go to IDLE next cycle.
REQ-024 SHALL toggle blink every BLINK_HALF cycles while edit_active, starting high on entry to DAY; blink SHALL be 0 in IDLE, with its counter cleared on each state change.
REQ-025 SHALL wrap all counters safely: no counter exceeds its parameter; they saturate or reload, never roll over.

Reset
REQ-026 SHALL, with reset low at a clk edge, set state IDLE, field_sel=0, edit_active=0, inc_pulse=0, dec_pulse=0, blink=0, clear all counters, and load the button registers with 0.
REQ-027 SHALL honour reset mid-edit or mid-repeat: outputs are at reset values the cycle after, and a still-held button produces no pulse until released and pressed again.

Configuration
REQ-028 SHALL compile auto-repeat logic only when macro BUTTON_AUTO_REPEAT_EN is defined: a single held up/down button emits a pulse REPEAT_DELAY cycles after its press pulse, then every REPEAT_RATE cycles while held.
REQ-029 SHALL, without BUTTON_AUTO_REPEAT_EN, emit exactly one pulse per press regardless of hold time, and REPEAT_DELAY/REPEAT_RATE are unused.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=100, BLINK_HALF=5)
REQ-030 SHALL cover: reset low 2 cycles, then 6 btn_mode presses -> field_sel 1,2,3,4,5,0, one step per press, edit_active high only for 1..5.
REQ-031 SHALL cover: field_sel=1, btn_up pulsed at edge k -> inc_pulse high only at cycle k+1; same in IDLE -> no pulse.
REQ-032 SHALL cover: BUTTON_AUTO_REPEAT_EN defined, btn_up held 30 cycles in DAY -> pulses at k+1, k+9, k+13, k+17, k+21, k+25, k+29; without macro -> only k+1.
REQ-033 SHALL cover: btn_mode and btn_up rising same cycle in DAY -> field_sel=2, no inc_pulse; btn_up and btn_down together -> no pulse.
REQ-034 SHALL cover: enter DAY, no activity 100 cycles -> field_sel=0, blink=0; blink toggles every 5 cycles before timeout.
REQ-035 SHALL cover: reset low during repeat with btn_up held -> no pulse until btn_up released and re-pressed.
